// File: rtl/ext_bus_bridge_pkg.sv
// Shared types and constants for the external bus bridge.
// State encodings, byte-select codes and the timeout error value.
package ext_bus_bridge_pkg;

    typedef enum logic [2:0] {
        EB_IDLE  = 3'd0,
        EB_SETUP = 3'd1,
        EB_REQ   = 3'd2,
        EB_REL   = 3'd3,
        EB_DONE  = 3'd4
    } eb_state_e;

    localparam logic [2:0] BS_BYTE = 3'b000;
    localparam logic [2:0] BS_HALF = 3'b001;
    localparam logic [2:0] BS_WORD = 3'b010;

    localparam logic [31:0] ERR_VALUE_DEF = 32'hFFFF_FFFF;

    // Index of the final beat for a byte select; unknown codes act as word.
    function automatic logic [1:0] last_beat(input logic [2:0] sel);
        logic [1:0] r;
        case (sel)
            BS_BYTE: r = 2'd0;
            BS_HALF: r = 2'd1;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Shared by the bridge ack path and the controller interrupt input.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    // Two register stages to settle metastability
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/ext_bus_bridge.sv
// Word request to byte-wide 4-phase req/ack external bus bridge.
// Splits a request into 1/2/4 little-endian beats with per-beat timeout.
module ext_bus_bridge
    import ext_bus_bridge_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    EXTADDR_WIDTH = 16,
    parameter int                    TIMEOUT_CYC   = 1023,
    parameter logic [DATA_WIDTH-1:0] ERR_VALUE     = DATA_WIDTH'(ERR_VALUE_DEF)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     mem_ext_drv,
    input  logic [ADDR_WIDTH-1:0]    mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_write,
    input  logic                     ext_we,
    input  logic [2:0]               mem_byte_sel,
    output logic [DATA_WIDTH-1:0]    ext_val_in,
    output logic                     transfer_ok,
    output logic                     bus_err,
    output logic                     ext_busy,
    output logic [EXTADDR_WIDTH-1:0] ext_addr,
    output logic [7:0]               ext_dout,
    input  logic [7:0]               ext_din,
    output logic                     ext_wr,
    output logic                     ext_oe,
    output logic                     ext_req,
    input  logic                     ext_ack
);

    localparam logic [9:0] TO_LIM = 10'(TIMEOUT_CYC);

    eb_state_e state_q, state_d;

    logic [EXTADDR_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [DATA_WIDTH-1:0]    rdbuf_q, rdbuf_d;
    logic [DATA_WIDTH-1:0]    val_q, val_d;
    logic [EXTADDR_WIDTH-1:0] addr_q, addr_d;
    logic [9:0]               cnt_q, cnt_d;
    logic [7:0]               dout_q, dout_d;
    logic [1:0]               k_q, k_d;
    logic [1:0]               last_q, last_d;
    logic                     we_q, we_d;
    logic                     ok_q, ok_d;
    logic                     err_q, err_d;
    logic                     busy_q, busy_d;
    logic                     wr_q, wr_d;
    logic                     req_q, req_d;

    logic       ack_s;
    logic       tick;
    logic [1:0] k_nxt;
    logic       unused_addr_hi;

    assign unused_addr_hi = ^mem_addr[ADDR_WIDTH-1:EXTADDR_WIDTH];
    assign k_nxt          = k_q + 2'd1;

    sync_2ff #(
        .WIDTH(1)
    ) u_ack_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (ext_ack),
        .q      (ack_s)
    );

    // Next-state logic: capture, beat sequencing and timeout abort
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        data_d  = data_q;
        rdbuf_d = rdbuf_q;
        val_d   = val_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        k_d     = k_q;
        last_d  = last_q;
        we_d    = we_q;
        ok_d    = 1'b0;
        err_d   = err_q;
        busy_d  = busy_q;
        wr_d    = wr_q;
        req_d   = req_q;
        tick    = 1'b0;

        unique case (state_q)
            EB_IDLE: begin
                if (mem_ext_drv) begin
                    base_d  = mem_addr[EXTADDR_WIDTH-1:0];
                    data_d  = mem_write;
                    we_d    = ext_we;
                    last_d  = last_beat(mem_byte_sel);
                    k_d     = 2'd0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    rdbuf_d = '0;
                    addr_d  = mem_addr[EXTADDR_WIDTH-1:0];
                    dout_d  = mem_write[7:0];
                    wr_d    = ext_we;
                    busy_d  = 1'b1;
                    state_d = EB_SETUP;
                end
            end
            EB_SETUP: begin
                // A stale ack from an aborted beat must clear first
                if (!ack_s) begin
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = EB_REQ;
                end else begin
                    tick = 1'b1;
                end
            end
            EB_REQ: begin
                if (ack_s) begin
                    if (!we_q) begin
                        rdbuf_d[{k_q, 3'b000} +: 8] = ext_din;
                    end
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = EB_REL;
                end else begin
                    tick = 1'b1;
                end
            end
            EB_REL: begin
                if (!ack_s) begin
                    if (k_q == last_q) begin
                        if (!we_q) begin
                            val_d = rdbuf_q;
                        end
                        ok_d    = 1'b1;
                        state_d = EB_DONE;
                    end else begin
                        k_d     = k_nxt;
                        addr_d  = base_q + EXTADDR_WIDTH'(k_nxt);
                        dout_d  = data_q[{k_nxt, 3'b000} +: 8];
                        state_d = EB_SETUP;
                    end
                end else begin
                    tick = 1'b1;
                end
            end
            EB_DONE: begin
                busy_d  = 1'b0;
                state_d = EB_IDLE;
            end
            default: begin
                state_d = EB_IDLE;
            end
        endcase

        if (tick) begin
            if (cnt_q == TO_LIM) begin
                req_d   = 1'b0;
                err_d   = 1'b1;
                ok_d    = 1'b1;
                if (!we_q) begin
                    val_d = ERR_VALUE;
                end
                state_d = EB_DONE;
            end else begin
                cnt_d = cnt_q + 10'd1;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EB_IDLE;
            base_q  <= '0;
            data_q  <= '0;
            rdbuf_q <= '0;
            val_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            k_q     <= '0;
            last_q  <= '0;
            we_q    <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            wr_q    <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            data_q  <= data_d;
            rdbuf_q <= rdbuf_d;
            val_q   <= val_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            k_q     <= k_d;
            last_q  <= last_d;
            we_q    <= we_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            wr_q    <= wr_d;
            req_q   <= req_d;
        end
    end

    assign ext_val_in  = val_q;
    assign transfer_ok = ok_q;
    assign bus_err     = err_q;
    assign ext_busy    = busy_q;
    assign ext_addr    = addr_q;
    assign ext_dout    = dout_q;
    assign ext_wr      = wr_q;
    assign ext_req     = req_q;
    assign ext_oe      = req_q & wr_q;

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Directed bench for ext_bus_bridge with a byte-wide 4-phase device model.
// Device reacts on falling edges; bench samples on falling edges.
module tb_ext_bus_bridge;
    import ext_bus_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_ext_drv = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_write = '0;
    logic        ext_we = 1'b0;
    logic [2:0]  mem_byte_sel = '0;
    logic [31:0] ext_val_in;
    logic        transfer_ok;
    logic        bus_err;
    logic        ext_busy;
    logic [15:0] ext_addr;
    logic [7:0]  ext_dout;
    logic [7:0]  ext_din = '0;
    logic        ext_wr;
    logic        ext_oe;
    logic        ext_req;
    logic        ext_ack = 1'b0;

    always #5 clk = ~clk;

    ext_bus_bridge dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_ext_drv (mem_ext_drv),
        .mem_addr    (mem_addr),
        .mem_write   (mem_write),
        .ext_we      (ext_we),
        .mem_byte_sel(mem_byte_sel),
        .ext_val_in  (ext_val_in),
        .transfer_ok (transfer_ok),
        .bus_err     (bus_err),
        .ext_busy    (ext_busy),
        .ext_addr    (ext_addr),
        .ext_dout    (ext_dout),
        .ext_din     (ext_din),
        .ext_wr      (ext_wr),
        .ext_oe      (ext_oe),
        .ext_req     (ext_req),
        .ext_ack     (ext_ack)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int a);
        logic [31:0] v;
        v = a;
        return v[7:0] ^ v[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] pat_word(input int a);
        return {pat((a + 3) & 16'hFFFF), pat((a + 2) & 16'hFFFF),
                pat((a + 1) & 16'hFFFF), pat(a & 16'hFFFF)};
    endfunction

    // Device model state
    logic [7:0]  dmem [0:65535];
    int          dev_lat = 1;
    int          lat_cnt = 0;
    bit          dev_stuck = 1'b0;
    bit          mute_en = 1'b0;
    logic [15:0] mute_addr = '0;
    logic [15:0] beat_log [$];
    int          ok_cnt = 0;
    logic        prev_req = 1'b0;
    logic [24:0] held;

    // Device responder plus protocol and stability checks
    always @(negedge clk) begin
        chk("oe_eq_req_and_wr", 32'(ext_oe), 32'(ext_req & ext_wr));
        if (ext_req && prev_req)
            chk("beat_stable", 32'({ext_addr, ext_dout, ext_wr}), 32'(held));
        if (ext_req && !prev_req) begin
            held = {ext_addr, ext_dout, ext_wr};
            chk("req_rise_ack_low", 32'(ext_ack), 32'd0);
        end
        prev_req = ext_req;
        if (transfer_ok) ok_cnt++;
        if (!ext_req) lat_cnt = 0;
        if (dev_stuck) begin
            ext_ack = 1'b1;
        end else if (ext_ack) begin
            if (!ext_req) ext_ack = 1'b0;
        end else if (ext_req && !(mute_en && ext_addr == mute_addr)) begin
            if (lat_cnt >= dev_lat) begin
                lat_cnt = 0;
                ext_ack = 1'b1;
                if (ext_wr) begin
                    dmem[ext_addr] = ext_dout;
                    ext_din = 8'h00;
                end else begin
                    ext_din = dmem[ext_addr];
                end
                beat_log.push_back(ext_addr);
            end else begin
                lat_cnt++;
            end
        end
    end

    task automatic do_strobe(input logic [31:0] a, input logic [31:0] d,
                             input logic we, input logic [2:0] sel);
        @(negedge clk);
        mem_addr     = a;
        mem_write    = d;
        ext_we       = we;
        mem_byte_sel = sel;
        mem_ext_drv  = 1'b1;
        @(negedge clk);
        mem_ext_drv  = 1'b0;
    endtask

    task automatic wait_ok(input string tag, input int budget,
                           output int cyc);
        cyc = 0;
        while (transfer_ok !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_ok_seen"}, 32'(transfer_ok), 32'd1);
    endtask

    task automatic wait_req_at(input string tag, input logic [15:0] a,
                               input int budget);
        int c;
        c = 0;
        while (!(ext_req === 1'b1 && ext_addr === a) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_req_seen"}, 32'(ext_req), 32'd1);
    endtask

    // Stop a runaway simulation
    initial begin
        #3ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int okc0;
        int hi;
        int seq_err;
        logic [31:0] a;

        for (int i = 0; i < 65536; i++) dmem[i] = pat(i);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_val", ext_val_in, 32'd0);
        chk("rst_ctl", 32'({transfer_ok, bus_err, ext_busy, ext_wr, ext_oe,
                            ext_req}), 32'd0);
        chk("rst_addr_dout", 32'({ext_addr, ext_dout}), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Word read with ack latency 1
        dmem[0] = 8'h11; dmem[1] = 8'h22; dmem[2] = 8'h33; dmem[3] = 8'h44;
        dev_lat = 1;
        beat_log.delete();
        okc0 = ok_cnt;
        do_strobe(32'h0001_0000, 32'h0, 1'b0, BS_WORD);
        chk("t1_busy_start", 32'(ext_busy), 32'd1);
        wait_ok("t1", 200, cyc);
        chk("t1_lat_ge5", 32'(cyc >= 5), 32'd1);
        chk("t1_busy_at_ok", 32'(ext_busy), 32'd1);
        chk("t1_val", ext_val_in, 32'h4433_2211);
        chk("t1_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        chk("t1_ok_one_cycle", 32'(transfer_ok), 32'd0);
        chk("t1_busy_end", 32'(ext_busy), 32'd0);
        chk("t1_nbeats", 32'(beat_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("t1_beat_addr", 32'(beat_log[i]), 32'(i));
        chk("t1_ok_count", 32'(ok_cnt - okc0), 32'd1);

        // Byte write
        dmem[7] = 8'h00;
        beat_log.delete();
        okc0 = ok_cnt;
        do_strobe(32'h0001_0007, 32'h0000_00A5, 1'b1, BS_BYTE);
        wait_req_at("t2", 16'h0007, 50);
        chk("t2_drive", 32'({ext_addr, ext_dout, ext_wr, ext_oe}),
            32'({16'h0007, 8'hA5, 1'b1, 1'b1}));
        wait_ok("t2", 200, cyc);
        chk("t2_val_kept", ext_val_in, 32'h4433_2211);
        chk("t2_oe_low_idle", 32'(ext_oe), 32'd0);
        @(negedge clk);
        chk("t2_nbeats", 32'(beat_log.size()), 32'd1);
        chk("t2_beat_addr", 32'(beat_log[0]), 32'h0007);
        chk("t2_mem", 32'(dmem[7]), 32'h00A5);
        chk("t2_ok_count", 32'(ok_cnt - okc0), 32'd1);

        // Half read across the address wrap
        dmem[16'hFFFF] = 8'hCD;
        dmem[0] = 8'hAB;
        dev_lat = 2;
        beat_log.delete();
        do_strobe(32'h0000_FFFF, 32'h0, 1'b0, BS_HALF);
        wait_ok("t3", 200, cyc);
        chk("t3_val", ext_val_in, 32'h0000_ABCD);
        @(negedge clk);
        chk("t3_nbeats", 32'(beat_log.size()), 32'd2);
        chk("t3_beat0", 32'(beat_log[0]), 32'h0000_FFFF);
        chk("t3_beat1", 32'(beat_log[1]), 32'h0000_0000);

        // Timeout on beat 2 of a word read
        mute_en = 1'b1;
        mute_addr = 16'h0101;
        dev_lat = 0;
        beat_log.delete();
        okc0 = ok_cnt;
        do_strobe(32'h0000_0100, 32'h0, 1'b0, BS_WORD);
        wait_req_at("t4", 16'h0101, 100);
        hi = 0;
        while (ext_req === 1'b1 && hi < 2000) begin
            hi++;
            @(negedge clk);
        end
        chk("t4_req_high_cycles", 32'(hi), 32'd1024);
        chk("t4_ok_at_drop", 32'(transfer_ok), 32'd1);
        chk("t4_val_err", ext_val_in, 32'hFFFF_FFFF);
        chk("t4_bus_err", 32'(bus_err), 32'd1);
        @(negedge clk);
        chk("t4_err_sticky", 32'(bus_err), 32'd1);
        chk("t4_nbeats", 32'(beat_log.size()), 32'd1);
        chk("t4_ok_count", 32'(ok_cnt - okc0), 32'd1);
        mute_en = 1'b0;

        // Stuck-high ack holds the next request in setup
        dev_stuck = 1'b1;
        repeat (4) @(negedge clk);
        do_strobe(32'h0000_0200, 32'h0, 1'b0, BS_BYTE);
        chk("t5_err_cleared", 32'(bus_err), 32'd0);
        repeat (20) @(negedge clk);
        chk("t5_held", 32'({ext_req, ext_busy, transfer_ok}), 32'b010);
        dev_stuck = 1'b0;
        wait_ok("t5", 200, cyc);
        chk("t5_val", ext_val_in, 32'(pat(32'h200)));
        chk("t5_err", 32'(bus_err), 32'd0);
        @(negedge clk);

        // Back-to-back word reads from a copy loop
        beat_log.delete();
        okc0 = ok_cnt;
        for (int i = 0; i < 200; i++) begin
            a = 32'h0000_1000 + 32'(4 * i);
            dev_lat = i % 3;
            do_strobe(a, 32'h0, 1'b0, BS_WORD);
            wait_ok("t6", 300, cyc);
            chk("t6_val", ext_val_in, pat_word(int'(a)));
        end
        @(negedge clk);
        chk("t6_ok_count", 32'(ok_cnt - okc0), 32'd200);
        chk("t6_nbeats", 32'(beat_log.size()), 32'd800);
        seq_err = 0;
        for (int i = 0; i < beat_log.size(); i++)
            if (beat_log[i] !== 16'(32'h1000 + i)) seq_err++;
        chk("t6_beat_seq", 32'(seq_err), 32'd0);

        // Reset during REQ of beat 3
        dev_lat = 1;
        do_strobe(32'h0000_2000, 32'h0, 1'b0, BS_WORD);
        wait_req_at("t7", 16'h2002, 100);
        okc0 = ok_cnt;
        reset_n = 1'b0;
        #1;
        chk("t7_req_async", 32'(ext_req), 32'd0);
        chk("t7_ctl", 32'({transfer_ok, bus_err, ext_busy, ext_wr, ext_oe}),
            32'd0);
        chk("t7_val", ext_val_in, 32'd0);
        chk("t7_addr", 32'(ext_addr), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t7_no_ok", 32'(ok_cnt - okc0), 32'd0);
        beat_log.delete();
        do_strobe(32'h0000_3000, 32'h0, 1'b0, BS_WORD);
        wait_ok("t7_fresh", 300, cyc);
        chk("t7_fresh_val", ext_val_in, pat_word(32'h3000));
        @(negedge clk);
        chk("t7_fresh_nbeats", 32'(beat_log.size()), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
